load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all data and address paths SHALL be 64 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 req_valid  input  1  datapath presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE and only while rst is low.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores use 000 SB, 001 SH, 010 SW, 011 SD.
REQ-008 req_addr  input  64  byte address.
REQ-009 req_wdata  input  64  store data; the valid bytes are the low-order bytes.
REQ-010 resp_valid  output  1  one-cycle pulse marking request completion.
REQ-011 resp_rdata  output  64  extended load result; 0 for stores and for errors.
REQ-012 resp_error  output  1  misaligned address or illegal funct3; qualified by resp_valid.
REQ-013 MemWrite, MemRead  output  1 each  data memory strobes.
REQ-014 MemAddr  output  64  doubleword-aligned address; bits [2:0] SHALL always be 0.
REQ-015 WriteData  output  64  full doubleword to be written.
REQ-016 ReadData  input  64  data memory read data; combinational on MemAddr while MemRead is high.

Function
REQ-017 Requests SHALL be accepted only on a clock edge where req_valid and req_ready are both high; all req_* fields SHALL be captured at that edge.
REQ-018 FSM states SHALL be IDLE, RD, WR and RESP.
REQ-019 Byte lane k SHALL be data bits [8k+7:8k] and SHALL be selected by req_addr[2:0] (little-endian).
REQ-020 Alignment rules: a halfword requires addr[0]=0, a word requires addr[1:0]=0, and a doubleword requires addr[2:0]=0.
REQ-021 Illegal funct3 values: 111 for loads; any value with funct3[2]=1 for stores.
REQ-022 Error request: IDLE -> RESP with resp_error=1; no MemRead or MemWrite SHALL be asserted.
REQ-023 Load: IDLE -> RD -> RESP. In RD, MemRead=1 and MemAddr={addr[63:3],3'b000}; ReadData SHALL be captured at the end of RD.
REQ-024 Load result: the selected bytes SHALL be sign-extended (LB, LH, LW) or zero-extended (LBU, LHU, LWU) to 64 bits; LD SHALL return ReadData unchanged.
REQ-025 SD: IDLE -> WR -> RESP. In WR, MemWrite=1 and WriteData=req_wdata.
REQ-026 SB/SH/SW: IDLE -> RD -> WR -> RESP (read-modify-write).
REQ-027 In the WR state of a read-modify-write, WriteData SHALL equal the captured doubleword with only the addressed lanes replaced by the low bytes of req_wdata.
REQ-028 In RESP, resp_valid=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 Latency from the accept edge to resp_valid high: 1 cycle for errors, 2 cycles for loads and SD, 3 cycles for SB/SH/SW.
REQ-030 MemRead and MemWrite SHALL never be high in the same cycle; both SHALL be low in IDLE and RESP.
REQ-031 MemAddr and WriteData SHALL be 0 whenever both strobes are low.
REQ-032 A request held on req_valid while the unit is busy SHALL be ignored until the FSM returns to IDLE.
REQ-033 Back-to-back requests SHALL be allowed: the earliest next accept is the cycle after RESP.

Reset
REQ-034 While rst is high at a clock edge, the next state SHALL be IDLE and the captured request SHALL be discarded.
REQ-035 Reset values: resp_valid=0, resp_rdata=0, resp_error=0, MemRead=0, MemWrite=0, MemAddr=0, WriteData=0.
REQ-036 req_ready SHALL be 0 during the reset cycle and 1 in the first cycle after rst falls.
REQ-037 Reset asserted in RD or WR SHALL abort the request: no MemWrite in any later cycle and no resp_valid for the aborted request.

Verification
REQ-038 Reset, then SD addr=63 -> resp_error=1 at +1 cycle, no memory strobe; SD addr=56 wdata=99 -> MemWrite=1 with MemAddr=56, WriteData=99, then resp_valid with error=0.
REQ-039 Memory dword at 8 = 0x00000000_0000001F; LB addr=8 -> resp_rdata=0x1F at +2 cycles; LD addr=8 -> 0x1F.
REQ-040 Dword at 16 = 0x0123456789ABCDEF:
- LH addr=18 -> 0xFFFFFFFFFFFF89AB; LHU addr=18 -> 0x89AB.
- LW addr=20 -> 0x0000000001234567.
- LH addr=19 -> resp_error=1.
REQ-041 Dword at 16 = 0x0123456789ABCDEF; SB addr=17 wdata=0x55 -> RD then WR with WriteData=0x0123456789AB55EF; resp_valid at +3 cycles; a subsequent LD addr=16 returns the same value.
REQ-042 Assert rst during WR of an SW -> MemWrite low from the next cycle and no resp_valid; the next request completes normally.
REQ-043 Hold req_valid high through a load -> exactly one RD per accept; the second accept occurs in the cycle after RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for a 64-bit datapath against a doubleword-wide data memory.
// Sub-doubleword stores are done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a new request
// RD    | MemRead asserted, doubleword captured at end of cycle
// WR    | MemWrite asserted with full or merged doubleword
// RESP  | one-cycle completion pulse on resp_valid
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [63:0] MemAddr,
  output logic [63:0] WriteData,
  input  logic [63:0] ReadData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] dword_q;
  logic        error_q;

  logic        accept;
  logic        req_misaligned;
  logic        req_illegal;
  logic        req_err;

  logic [5:0]  lane_sh;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [63:0] merged;
  logic [63:0] store_dword;
  logic [63:0] lane_data;
  logic [63:0] load_result;
  logic        rd_active;
  logic        wr_active;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
  end

  assign req_illegal = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
  assign req_err     = req_misaligned || req_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 64'h0;
      wdata_q  <= 64'h0;
      dword_q  <= 64'h0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        error_q  <= req_err;
      end
      if (state_q == RD) begin
        dword_q <= ReadData;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && (req_funct3[1:0] == 2'b11)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lane_sh = {addr_q[2:0], 3'b000};

  always_comb begin
    size_mask = 64'h0;
    case (funct3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign lane_mask   = size_mask << lane_sh;
  assign merged      = (dword_q & ~lane_mask) | ((wdata_q & size_mask) << lane_sh);
  assign store_dword = (funct3_q[1:0] == 2'b11) ? wdata_q : merged;

  // addressed bytes moved down to lane 0 before extension
  assign lane_data = dword_q >> lane_sh;

  always_comb begin
    load_result = 64'h0;
    case (funct3_q)
      3'b000:  load_result = {{56{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_result = {{48{lane_data[15]}}, lane_data[15:0]};
      3'b010:  load_result = {{32{lane_data[31]}}, lane_data[31:0]};
      3'b011:  load_result = lane_data;
      3'b100:  load_result = {56'h0, lane_data[7:0]};
      3'b101:  load_result = {48'h0, lane_data[15:0]};
      3'b110:  load_result = {32'h0, lane_data[31:0]};
      default: load_result = 64'h0;
    endcase
  end

  // strobes are gated by rst so an abort in RD/WR takes effect in the reset cycle
  assign rd_active = (state_q == RD) && !rst;
  assign wr_active = (state_q == WR) && !rst;

  assign MemRead   = rd_active;
  assign MemWrite  = wr_active;
  assign MemAddr   = (rd_active || wr_active) ? {addr_q[63:3], 3'b000} : 64'h0;
  assign WriteData = wr_active ? store_dword : 64'h0;

  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_error = resp_valid && error_q;
  assign resp_rdata = (resp_valid && !error_q && !write_q) ? load_result : 64'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small memory model, a scoreboard of
// expected responses, and an invariant monitor on the memory strobes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_wdata = 64'h0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] MemAddr;
  logic [63:0] WriteData;
  logic [63:0] ReadData;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  logic [63:0] mem [16];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .MemAddr    (MemAddr),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  assign ReadData = MemRead ? mem[MemAddr[6:3]] : 64'h0;

  // memory contents are restored on every reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
      mem[1] <= 64'h0000_0000_0000_001F;
      mem[2] <= 64'h0123_4567_89AB_CDEF;
      mem[3] <= 64'hDEAD_BEEF_CAFE_F00D;
    end else if (MemWrite) begin
      mem[MemAddr[6:3]] <= WriteData;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_excl", 64'(MemRead & MemWrite), 64'h0);
      chk("memaddr_align", 64'(MemAddr[2:0]), 64'h0);
      if (!MemRead && !MemWrite) begin
        chk("idle_memaddr", MemAddr, 64'h0);
        chk("idle_wdata", WriteData, 64'h0);
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_rdata, input int exp_lat,
                        input int exp_reads, input int exp_writes,
                        input logic [63:0] exp_waddr, input logic [63:0] exp_wdata);
    exp_t        e;
    int          lat;
    int          reads;
    int          writes;
    logic [63:0] waddr;
    logic [63:0] wdat;
    logic [63:0] rdata;
    logic        err;
    logic        got;
    sb_q.push_back('{exp_err, exp_rdata, exp_lat});
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    chk({tag, "_ready"}, 64'(req_ready), 64'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0; reads = 0; writes = 0;
    waddr = 64'h0; wdat = 64'h0; rdata = 64'h0; err = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (MemRead) reads++;
      if (MemWrite) begin
        writes++;
        waddr = MemAddr;
        wdat  = WriteData;
      end
      if (resp_valid) begin
        got   = 1'b1;
        lat   = k;
        rdata = resp_rdata;
        err   = resp_error;
      end
    end
    chk({tag, "_resp_seen"}, 64'(got), 64'h1);
    e = sb_q.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_error"}, 64'(err), 64'(e.err));
    chk({tag, "_rdata"}, rdata, e.rdata);
    chk({tag, "_reads"}, 64'(reads), 64'(exp_reads));
    chk({tag, "_writes"}, 64'(writes), 64'(exp_writes));
    if (exp_writes > 0) begin
      chk({tag, "_waddr"}, waddr, exp_waddr);
      chk({tag, "_wdata"}, wdat, exp_wdata);
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, 64'(resp_valid), 64'h0);
    chk({tag, "_ready_again"}, 64'(req_ready), 64'h1);
  endtask

  initial begin
    int          n_wr;
    int          n_rv;
    logic [5:0]  rdy_v;
    logic [5:0]  rd_v;
    logic [5:0]  rv_v;
    exp_t        e;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_resp_error", 64'(resp_error), 64'h0);
    chk("rst_memread", 64'(MemRead), 64'h0);
    chk("rst_memwrite", 64'(MemWrite), 64'h0);
    chk("rst_memaddr", MemAddr, 64'h0);
    chk("rst_writedata", WriteData, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'h1);

    do_req("sd_mis63", 1'b1, 3'b011, 64'd63, 64'd0,   1'b1, 64'h0, 1, 0, 0, 64'h0, 64'h0);
    do_req("sd_56",    1'b1, 3'b011, 64'd56, 64'd99,  1'b0, 64'h0, 2, 0, 1, 64'd56, 64'd99);
    chk("mem56_after_sd", mem[7], 64'd99);
    do_req("lb8",      1'b0, 3'b000, 64'd8,  64'd0,   1'b0, 64'h1F, 2, 1, 0, 64'h0, 64'h0);
    do_req("ld8",      1'b0, 3'b011, 64'd8,  64'd0,   1'b0, 64'h1F, 2, 1, 0, 64'h0, 64'h0);
    do_req("lh18",     1'b0, 3'b001, 64'd18, 64'd0,   1'b0, 64'hFFFF_FFFF_FFFF_89AB, 2, 1, 0, 64'h0, 64'h0);
    do_req("lhu18",    1'b0, 3'b101, 64'd18, 64'd0,   1'b0, 64'h0000_0000_0000_89AB, 2, 1, 0, 64'h0, 64'h0);
    do_req("lw20",     1'b0, 3'b010, 64'd20, 64'd0,   1'b0, 64'h0000_0000_0123_4567, 2, 1, 0, 64'h0, 64'h0);
    do_req("lb17",     1'b0, 3'b000, 64'd17, 64'd0,   1'b0, 64'hFFFF_FFFF_FFFF_FFCD, 2, 1, 0, 64'h0, 64'h0);
    do_req("lbu17",    1'b0, 3'b100, 64'd17, 64'd0,   1'b0, 64'h0000_0000_0000_00CD, 2, 1, 0, 64'h0, 64'h0);
    do_req("lb23",     1'b0, 3'b000, 64'd23, 64'd0,   1'b0, 64'h0000_0000_0000_0001, 2, 1, 0, 64'h0, 64'h0);
    do_req("lh19",     1'b0, 3'b001, 64'd19, 64'd0,   1'b1, 64'h0, 1, 0, 0, 64'h0, 64'h0);
    do_req("ld_f7",    1'b0, 3'b111, 64'd8,  64'd0,   1'b1, 64'h0, 1, 0, 0, 64'h0, 64'h0);
    do_req("st_f4",    1'b1, 3'b100, 64'd8,  64'd0,   1'b1, 64'h0, 1, 0, 0, 64'h0, 64'h0);
    do_req("sw_mis",   1'b1, 3'b010, 64'd26, 64'd0,   1'b1, 64'h0, 1, 0, 0, 64'h0, 64'h0);
    do_req("sb17",     1'b1, 3'b000, 64'd17, 64'h55,  1'b0, 64'h0, 3, 1, 1, 64'd16, 64'h0123_4567_89AB_55EF);
    do_req("ld16",     1'b0, 3'b011, 64'd16, 64'd0,   1'b0, 64'h0123_4567_89AB_55EF, 2, 1, 0, 64'h0, 64'h0);
    do_req("sh30",     1'b1, 3'b001, 64'd30, 64'hABCD_1234, 1'b0, 64'h0, 3, 1, 1, 64'd24, 64'h1234_BEEF_CAFE_F00D);
    do_req("sw28",     1'b1, 3'b010, 64'd28, 64'hFFFF_FFFF_1122_3344, 1'b0, 64'h0, 3, 1, 1, 64'd24, 64'h1122_3344_CAFE_F00D);
    do_req("ld24",     1'b0, 3'b011, 64'd24, 64'd0,   1'b0, 64'h1122_3344_CAFE_F00D, 2, 1, 0, 64'h0, 64'h0);

    // abort an SW with reset while it is in WR
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 64'd32;
    req_wdata  = 64'hA5A5_A5A5;
    chk("abort_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rd_phase", 64'(MemRead), 64'h1);
    @(negedge clk);
    chk("abort_wr_phase", 64'(MemWrite), 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_wr = 0;
    n_rv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (MemWrite) n_wr++;
      if (resp_valid) n_rv++;
    end
    chk("abort_no_write", 64'(n_wr), 64'h0);
    chk("abort_no_resp", 64'(n_rv), 64'h0);
    do_req("ld_after_abort", 1'b0, 3'b011, 64'd8, 64'd0, 1'b0, 64'h1F, 2, 1, 0, 64'h0, 64'h0);
    do_req("sw_after_abort", 1'b1, 3'b010, 64'd32, 64'hA5A5_A5A5, 1'b0, 64'h0, 3, 1, 1, 64'd32, 64'h0000_0000_A5A5_A5A5);

    // req_valid held high across two back-to-back loads
    sb_q.push_back('{1'b0, 64'h1F, 2});
    sb_q.push_back('{1'b0, 64'h1F, 2});
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 64'd8;
    req_wdata  = 64'h0;
    rdy_v = 6'b0;
    rd_v  = 6'b0;
    rv_v  = 6'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      rdy_v[i] = req_ready;
      rd_v[i]  = MemRead;
      rv_v[i]  = resp_valid;
      if (resp_valid) begin
        e = sb_q.pop_front();
        chk("hold_rdata", resp_rdata, e.rdata);
        chk("hold_error", 64'(resp_error), 64'(e.err));
      end
    end
    req_valid = 1'b0;
    chk("hold_ready_pattern", 64'(rdy_v), 64'(6'b001001));
    chk("hold_read_pattern", 64'(rd_v), 64'(6'b010010));
    chk("hold_resp_pattern", 64'(rv_v), 64'(6'b100100));
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
